// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit carry-lookahead adder, one nibble per cycle.

module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;
  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum = p ^ c[3:0];
    cout = c[4];
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIB = WIDTH / 4;
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r;
  logic carry_r;
  logic [IW-1:0] idx;
  logic [3:0] ns;
  logic nc;
  cla u_cla (
    .a(a_r[4*idx +: 4]),
    .b(b_r[4*idx +: 4]),
    .cin(carry_r),
    .sum(ns),
    .cout(nc)
  );
  // rst gates in_ready so no operand is acknowledged while reset is held
  assign in_ready = (state == IDLE) && !rst;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      carry_r <= 1'b0;
      idx <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= b;
          carry_r <= cin;
          idx <= '0;
          state <= RUN;
        end
        RUN: begin
          sum[4*idx +: 4] <= ns;
          carry_r <= nc;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            cout <= nc;
            ovf <= nc ^ (a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ ns[3]);
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed vectors for the 16-bit and 4-bit serial adders.

module tb_nibble_serial_adder;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;

  logic iv = 0, ir, ovld, ordy = 1, ci = 0, co, ov;
  logic [15:0] a = 0, b = 0, s;
  logic iv4 = 0, ir4, ovld4, ordy4 = 1, ci4 = 0, co4, ov4;
  logic [3:0] a4 = 0, b4 = 0, s4;
  int checks = 0, errors = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .cin(ci),
    .out_valid(ovld), .out_ready(ordy), .sum(s), .cout(co), .ovf(ov)
  );
  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(ci4),
    .out_valid(ovld4), .out_ready(ordy4), .sum(s4), .cout(co4), .ovf(ov4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready16();
    int n = 0;
    while (!ir && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ir) check("accept_timeout", 32'(ir), 1);
  endtask

  // lat = number of edges from the accept edge to the edge that captures out_valid=1
  task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic c,
                      output logic [15:0] rs, output logic rc, output logic rv, output int lat);
    wait_ready16();
    a = x; b = y; ci = c; iv = 1; ordy = 1;
    @(posedge clk);
    #1 iv = 0; a = 16'($urandom); b = 16'($urandom); ci = 1;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (ovld) break;
    end
    rs = s; rc = co; rv = ov;
    @(posedge clk);
    #1;
  endtask

  task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic c,
                     output logic [3:0] rs, output logic rc, output logic rv, output int lat);
    a4 = x; b4 = y; ci4 = c; iv4 = 1; ordy4 = 1;
    @(posedge clk);
    #1 iv4 = 0; a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (ovld4) break;
    end
    rs = s4; rc = co4; rv = ov4;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] sum;
    logic        cout, ovf;
  } vec_t;

  initial begin
    vec_t tbl[6];
    logic [15:0] rs;
    logic [3:0] rs4;
    logic rc, rv;
    int lat, cyc, n_acc, t0, t1, n;
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    #1 rst = 1;
    @(negedge clk);
    check("rst_in_ready", 32'(ir), 0);
    check("rst_out_valid", 32'(ovld), 0);
    check("rst_sum", 32'(s), 0);
    check("rst_cout_ovf", {co, ov}, 0);
    check("rst_in_ready4", 32'(ir4), 0);
    rst = 0;
    #1 check("post_rst_in_ready", 32'(ir), 1);

    foreach (tbl[i]) begin
      op16(tbl[i].a, tbl[i].b, tbl[i].cin, rs, rc, rv, lat);
      check($sformatf("v%0d_sum", i), 32'(rs), 32'(tbl[i].sum));
      check($sformatf("v%0d_cout", i), 32'(rc), 32'(tbl[i].cout));
      check($sformatf("v%0d_ovf", i), 32'(rv), 32'(tbl[i].ovf));
      check($sformatf("v%0d_latency", i), lat, 5);
    end

    // back-to-back accepts with in_valid and out_ready held high
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; ci = 1; iv = 1; ordy = 1;
    n_acc = 0; cyc = 0; t0 = 0; t1 = 0;
    while (n_acc < 2 && cyc < 40) begin
      if (ir) begin
        if (n_acc == 0) t0 = cyc; else t1 = cyc;
        n_acc++;
      end
      if (ovld) check("b2b_sum", 32'(s), 32'h5556);
      @(negedge clk);
      cyc++;
    end
    iv = 0;
    check("b2b_accepts", n_acc, 2);
    check("b2b_spacing", t1 - t0, 6);

    // result stalled by out_ready=0 while a new operand waits
    n = 0;
    while (ovld && n < 20) begin @(negedge clk); n++; end
    wait_ready16();
    a = 16'h1234; b = 16'h4321; ci = 1; iv = 1; ordy = 0;
    @(posedge clk);
    #1 a = 16'hAAAA; b = 16'h5555; ci = 0;
    n = 0;
    while (!ovld && n < 20) begin @(negedge clk); n++; end
    check("stall_valid_rises", 32'(ovld), 1);
    repeat (5) begin
      @(negedge clk);
      check("stall_sum", 32'(s), 32'h5556);
      check("stall_valid", 32'(ovld), 1);
      check("stall_in_ready", 32'(ir), 0);
    end
    ordy = 1;
    @(negedge clk);
    check("stall_release_valid", 32'(ovld), 0);
    check("stall_release_ready", 32'(ir), 1);
    iv = 0;

    // reset two cycles into RUN abandons the operation
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; ci = 0; iv = 1;
    @(posedge clk);
    #1 iv = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    check("midrst_in_ready", 32'(ir), 0);
    rst = 0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (ovld) n++;
    end
    check("midrst_no_result", n, 0);
    op16(16'h00FF, 16'h0001, 1'b0, rs, rc, rv, lat);
    check("after_rst_sum", 32'(rs), 32'h0100);
    check("after_rst_cout", 32'(rc), 0);

    op4(4'h9, 4'h8, 1'b0, rs4, rc, rv, lat);
    check("w4_sum", 32'(rs4), 1);
    check("w4_cout", 32'(rc), 1);
    check("w4_ovf", 32'(rv), 1);
    check("w4_latency", lat, 2);
    op4(4'h7, 4'h0, 1'b1, rs4, rc, rv, lat);
    check("w4_cin_sum", 32'(rs4), 8);
    check("w4_cin_flags", {rc, rv}, 32'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
